adder_mw_ctrl: RTL and testbench
================================

ADDER_MW_CTRL -- requirements
Module: adder_mw_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the bit width of the shared adder_rc word adder.
REQ-002 The block SHALL have parameter WORDS, default 4, meaning the number of words per operand; operand width N = WIDTH*WORDS.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  meaning the reset, asynchronous and active-low.
REQ-005 The block SHALL have port start  input  1  meaning the request to begin one N-bit addition.
REQ-006 The block SHALL have port a  input  N  meaning operand A.
REQ-007 The block SHALL have port b  input  N  meaning operand B.
REQ-008 The block SHALL have port ci  input  1  meaning the carry-in to word 0.
REQ-009 The block SHALL have port s  output  N  meaning the registered sum.
REQ-010 The block SHALL have port co  output  1  meaning the registered carry-out of word WORDS-1.
REQ-011 The block SHALL have port busy  output  1  meaning an addition is in progress (state RUN).
REQ-012 The block SHALL have port done  output  1  meaning s/co are final (state DONE), one-cycle pulse.

Function
REQ-013 The block SHALL instantiate exactly one adder_rc#(.WIDTH(WIDTH)) and time-share it across all words, least significant word first.
REQ-014 The FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL latch a, b, ci into internal registers, clear s and co to 0, set word index to 0, and enter RUN.
REQ-016 In IDLE with start=0 the block SHALL stay in IDLE with s, co unchanged.
REQ-017 In RUN, each rising edge SHALL write the adder sum of latched word[idx] of A and B plus the carry register into s word[idx], load the adder carry-out into the carry register, and increment idx.
REQ-018 On the RUN edge processing idx = WORDS-1, the block SHALL load co with that word's carry-out and enter DONE.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-020 busy SHALL equal 1 exactly while in RUN; done SHALL equal 1 exactly while in DONE; both decoded from state.
REQ-021 Latency: done SHALL be high in the cycle beginning WORDS rising edges after the edge that accepted start.
REQ-022 start SHALL be ignored in RUN and DONE; latched operands SHALL NOT change until the next acceptance.
REQ-023 With start held high continuously, a new addition SHALL be accepted every WORDS+2 cycles.
REQ-024 s and co SHALL hold their final values after DONE until the next acceptance.
REQ-025 Arithmetic SHALL be modulo 2^N for s, with co the true carry out of bit N-1; the word-to-word carry SHALL propagate through the carry register only.
REQ-026 idx SHALL be ceil(log2(WORDS)) bits wide, minimum 1 bit, and SHALL never exceed WORDS-1.

Reset
REQ-027 rst_n low SHALL immediately, without a clock edge, force state IDLE, idx 0, carry register 0, s 0, co 0, busy 0, done 0.
REQ-028 rst_n low during RUN or DONE SHALL abort the addition with no partial result retained.
REQ-029 The first rising edge with rst_n high and start=1 SHALL be a normal acceptance.

Verification (WIDTH=4, WORDS=4, N=16)
REQ-030 The bench SHALL cover: assert rst_n=0 -> s=0x0000, co=0, busy=0, done=0 with no clock edge.
REQ-031 The bench SHALL cover: a=0x00FF, b=0x0001, ci=0, start pulse -> busy=1 for 4 cycles, then done=1 for 1 cycle with s=0x0100, co=0.
REQ-032 The bench SHALL cover: a=0xFFFF, b=0x0000, ci=1 -> s=0x0000, co=1 at done (carry ripples across all 4 words).
REQ-033 The bench SHALL cover: a=0x1234, b=0x1111 accepted, then start with a=0xFFFF, b=0xFFFF during RUN -> ignored; done shows s=0x2345, co=0.
REQ-034 The bench SHALL cover: rst_n pulsed low in the 2nd RUN cycle -> outputs 0 at once, no done; then a=0x8000, b=0x8000, ci=0 -> s=0x0000, co=1.
REQ-035 The bench SHALL cover: start held high with constant a=0x0001, b=0x0002 -> done pulses every 6 cycles, each with s=0x0003, co=0.

Source files
------------

// File: rtl/adder_mw_ctrl.sv
// Multi-word adder controller. One WIDTH-bit ripple-carry adder is
// time-shared over WORDS words, least significant word first. The
// word-to-word carry passes only through a carry register.

// Ripple-carry word adder. It is built from a chain of per-bit full adders.
module adder_rc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    logic [WIDTH:0] c;

    assign c[0] = ci;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign s[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign co = c[WIDTH];
endmodule

module adder_mw_ctrl #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   ci,
    output logic [WIDTH*WORDS-1:0] s,
    output logic                   co,
    output logic                   busy,
    output logic                   done
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // The operands are held word-addressable so that idx selects the word directly.
    logic [WORDS-1:0][WIDTH-1:0] a_q, b_q, s_q;
    logic [IW-1:0]               idx;
    logic                        carry_q;

    logic [WIDTH-1:0] word_sum;
    logic             word_co;

    // Single shared adder. The inputs come from the current word and the carry register.
    adder_rc #(.WIDTH(WIDTH)) u_adder (
        .a  (a_q[idx]),
        .b  (b_q[idx]),
        .ci (carry_q),
        .s  (word_sum),
        .co (word_co)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic. Start is sampled only in IDLE. DONE always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath. It latches the operands on acceptance and writes one word per RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            co      <= 1'b0;
            idx     <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= ci;
                        s_q     <= '0;
                        co      <= 1'b0;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    s_q[idx] <= word_sum;
                    carry_q  <= word_co;
                    if (idx == LAST) begin
                        co  <= word_co;
                        idx <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s    = s_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_adder_mw_ctrl.sv
// Directed bench for adder_mw_ctrl (WIDTH=4, WORDS=4). A vector table covers
// the arithmetic. Hand-written sequences cover the behaviour of start
// during RUN, reset in the middle of an addition, and back-to-back operation.
module tb_adder_mw_ctrl;
    localparam int WIDTH = 4;
    localparam int WORDS = 4;
    localparam int N     = WIDTH * WORDS;

    logic         clk, rst_n, start, ci;
    logic [N-1:0] a, b, s;
    logic         co, busy, done;

    int checks = 0;
    int errors = 0;

    adder_mw_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .s     (s),
        .co    (co),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         ci;
        logic [N-1:0] s;
        logic         co;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // This task issues one start pulse and then follows the full transaction, sampling at negedges.
    task automatic do_add(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vci,
                          input logic [N-1:0] es, input logic eco, input string name);
        @(negedge clk);
        a = va; b = vb; ci = vci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, " s cleared"}, s, 0);
        for (int i = 0; i < WORDS; i++) begin
            if (i > 0) @(negedge clk);
            check({name, " busy"}, busy, 1);
            check({name, " done low"}, done, 0);
        end
        @(negedge clk);
        check({name, " done"}, done, 1);
        check({name, " busy low"}, busy, 0);
        check({name, " s"}, s, es);
        check({name, " co"}, co, eco);
        @(negedge clk);
        check({name, " done pulse"}, done, 0);
        check({name, " s held"}, s, es);
        check({name, " co held"}, co, eco);
    endtask

    initial begin
        logic [N-1:0] part [4];

        vt[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vt[2] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
        vt[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vt[4] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1};
        vt[5] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0};
        vt[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        vt[7] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};

        // Reset is asserted from time zero and checked before any clock edge.
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        #2;
        check("reset s", s, 0);
        check("reset co", co, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle busy", busy, 0);
        check("idle s", s, 0);

        foreach (vt[i])
            do_add(vt[i].a, vt[i].b, vt[i].ci, vt[i].s, vt[i].co, $sformatf("vec%0d", i));

        // A start during RUN is ignored. The partial sums show the word order, LSW first.
        part[0] = 16'h0005; part[1] = 16'h0045; part[2] = 16'h0345; part[3] = 16'h2345;
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1;   // start stays high through RUN
        for (int i = 0; i < WORDS; i++) begin
            @(negedge clk);
            check($sformatf("ign partial s%0d", i), s, part[i]);
        end
        start = 1'b0;
        check("ign done", done, 1);
        check("ign co", co, 0);
        @(negedge clk);
        check("ign idle", {busy, done}, 0);

        // Reset is pulsed in the second RUN cycle and must clear the outputs without a clock edge.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort busy before", busy, 1);
        check("abort partial s", s, 16'h0005);
        rst_n = 1'b0;
        #1;
        check("abort s", s, 0);
        check("abort co", co, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort no done", done, 0);
            check("abort s stays 0", s, 0);
        end
        do_add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "after abort");

        // When start is held high, a done pulse is expected every WORDS+2 cycles.
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; ci = 1'b0; start = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            check($sformatf("stream done k%0d", k), done, (k % 6 == 4) ? 1 : 0);
            if (k % 6 == 4) begin
                check("stream s", s, 16'h0003);
                check("stream co", co, 0);
            end
        end
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
